// File: rtl/online_div_ctrl_v3_pkg.sv
// Shared definitions for the online divider controller: signed-digit encoding,
// FSM state codes and the digit sanitiser.
package online_div_pkg;

    localparam logic [1:0] SD_POS     = 2'b10;
    localparam logic [1:0] SD_NEG     = 2'b01;
    localparam logic [1:0] SD_ZERO    = 2'b00;
    localparam logic [1:0] SD_ILLEGAL = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_REFRESH = 3'd1;
    localparam state_t S_DELAY   = 3'd2;
    localparam state_t S_ITER    = 3'd3;
    localparam state_t S_FLUSH   = 3'd4;
    localparam state_t S_DRAIN   = 3'd5;

    // The illegal 11 code is forced to zero so the datapath never sees it.
    function automatic logic [1:0] sd_sanitise(input logic [1:0] digit);
        logic [1:0] clean;
        case (digit)
            SD_POS, SD_NEG, SD_ZERO: clean = digit;
            default:                 clean = SD_ZERO;
        endcase
        return clean;
    endfunction

endpackage

// File: rtl/online_div_ctrl_v3_sd_digit_reg.sv
// Registers the sanitised x/d digit pair for the datapath and keeps a sticky
// flag recording any illegal digit accepted since the last clear.
module sd_digit_reg
    import online_div_pkg::*;
(
    input  logic       clk,
    input  logic       asyn_reset,
    input  logic       clear,
    input  logic       load,
    input  logic       zero,
    input  logic [1:0] x_value,
    input  logic [1:0] d_value,
    output logic [1:0] x_value_comp,
    output logic [1:0] d_value_comp,
    output logic       digit_err
);

    logic illegal;

    assign illegal = (x_value == SD_ILLEGAL) || (d_value == SD_ILLEGAL);

    // Flush steps load zero digits and must not raise the error flag.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            x_value_comp <= SD_ZERO;
            d_value_comp <= SD_ZERO;
            digit_err    <= 1'b0;
        end else begin
            if (load) begin
                x_value_comp <= zero ? SD_ZERO : sd_sanitise(x_value);
                d_value_comp <= zero ? SD_ZERO : sd_sanitise(d_value);
            end
            if (clear) begin
                digit_err <= 1'b0;
            end else if (load && !zero && illegal) begin
                digit_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/online_div_ctrl_v3.sv
// Sequencing controller for the radix-2 signed-digit online divider: digit
// intake handshake, online-delay/iteration/flush stepping and quotient re-timing.
module online_div_ctrl_v3
    import online_div_pkg::*;
#(
    parameter int PRECISION    = 64,
    parameter int ONLINE_DELAY = 3,
    parameter int ADDR_WIDTH   = 7,
    parameter int CNT_WIDTH    = 11
) (
    input  logic                  clk,
    input  logic                  asyn_reset,
    input  logic                  start,
    input  logic [1:0]            x_value,
    input  logic [1:0]            d_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            q_value,
    output logic [1:0]            x_value_comp,
    output logic [1:0]            d_value_comp,
    output logic                  enable,
    output logic                  refresh,
    output logic [CNT_WIDTH-1:0]  counter,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [1:0]            q_out,
    output logic                  q_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  digit_err
);

    localparam logic [CNT_WIDTH-1:0] LAST_DELAY  =
        CNT_WIDTH'((ONLINE_DELAY > 0) ? ONLINE_DELAY - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] LAST_ACCEPT = CNT_WIDTH'(PRECISION - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_STEP   = CNT_WIDTH'(PRECISION + ONLINE_DELAY - 1);

    state_t               state;
    state_t               next_state;
    logic [CNT_WIDTH-1:0] step_cnt;
    logic                 accept;
    logic                 flushing;
    logic                 issue;
    logic                 q_take;

    assign in_ready = (state == S_DELAY) || (state == S_ITER);
    assign accept   = in_ready && in_valid;
    assign flushing = (state == S_FLUSH);
    assign issue    = accept || flushing;
    assign refresh  = (state == S_REFRESH);
    assign busy     = (state != S_IDLE);
    assign wr_addr  = counter[ADDR_WIDTH-1:0];
    // Steps before the online delay produce no quotient digit.
    assign q_take   = enable && (int'(counter) >= ONLINE_DELAY);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_REFRESH;
            end
            S_REFRESH: begin
                next_state = (ONLINE_DELAY == 0) ? S_ITER : S_DELAY;
            end
            S_DELAY: begin
                if (accept && step_cnt == LAST_DELAY) next_state = S_ITER;
            end
            S_ITER: begin
                if (accept && step_cnt == LAST_ACCEPT)
                    next_state = (ONLINE_DELAY == 0) ? S_DRAIN : S_FLUSH;
            end
            S_FLUSH: begin
                if (step_cnt == LAST_STEP) next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (done) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // A step issued this cycle is strobed to the datapath next cycle; its
    // quotient digit is captured at the end of that strobe cycle.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state    <= S_IDLE;
            step_cnt <= '0;
            enable   <= 1'b0;
            counter  <= '0;
            q_out    <= SD_ZERO;
            q_valid  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state  <= next_state;
            enable <= issue;
            if (refresh) begin
                step_cnt <= '0;
                counter  <= '0;
            end else if (issue) begin
                step_cnt <= step_cnt + CNT_WIDTH'(1);
                counter  <= step_cnt;
            end
            q_valid <= q_take;
            if (q_take) q_out <= q_value;
            done <= enable && (counter == LAST_STEP);
        end
    end

    sd_digit_reg u_digit_reg (
        .clk          (clk),
        .asyn_reset   (asyn_reset),
        .clear        (refresh),
        .load         (issue),
        .zero         (flushing),
        .x_value      (x_value),
        .d_value      (d_value),
        .x_value_comp (x_value_comp),
        .d_value_comp (d_value_comp),
        .digit_err    (digit_err)
    );

endmodule

// File: tb/tb_online_div_ctrl_v3.sv
// Scoreboard bench for online_div_ctrl_v3: expected strobes and quotient digits
// are queued as stimulus is issued and matched by a monitor on the DUT outputs.
module tb_online_div_ctrl_v3;

    localparam int P  = 64;
    localparam int D  = 3;
    localparam int P0 = 8;

    typedef struct {
        int         cyc;
        int         cnt;
        logic [1:0] xc;
        logic [1:0] dc;
    } en_t;

    typedef struct {
        int         cyc;
        logic [1:0] q;
        logic       dn;
    } q_t;

    logic        clk = 1'b0;
    logic        asyn_reset;
    logic        start;
    logic        in_valid;
    logic [1:0]  x_value;
    logic [1:0]  d_value;
    logic [1:0]  q_value;
    logic        in_ready;
    logic [1:0]  x_value_comp;
    logic [1:0]  d_value_comp;
    logic        enable;
    logic        refresh;
    logic [10:0] counter;
    logic [6:0]  wr_addr;
    logic [1:0]  q_out;
    logic        q_valid;
    logic        busy;
    logic        done;
    logic        digit_err;

    logic        s_start;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [1:0]  s_x_comp;
    logic [1:0]  s_d_comp;
    logic        s_enable;
    logic        s_refresh;
    logic [10:0] s_counter;
    logic [6:0]  s_wr_addr;
    logic [1:0]  s_q_out;
    logic        s_q_valid;
    logic        s_busy;
    logic        s_done;
    logic        s_digit_err;

    int  cyc = 0;
    int  passed = 0;
    int  total = 0;
    bit  err_model = 1'b0;
    en_t enq[$];
    q_t  qq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    online_div_ctrl_v3 #(
        .PRECISION(P), .ONLINE_DELAY(D), .ADDR_WIDTH(7), .CNT_WIDTH(11)
    ) dut (
        .clk(clk), .asyn_reset(asyn_reset), .start(start),
        .x_value(x_value), .d_value(d_value), .in_valid(in_valid),
        .in_ready(in_ready), .q_value(q_value),
        .x_value_comp(x_value_comp), .d_value_comp(d_value_comp),
        .enable(enable), .refresh(refresh), .counter(counter),
        .wr_addr(wr_addr), .q_out(q_out), .q_valid(q_valid),
        .busy(busy), .done(done), .digit_err(digit_err)
    );

    online_div_ctrl_v3 #(
        .PRECISION(P0), .ONLINE_DELAY(0), .ADDR_WIDTH(7), .CNT_WIDTH(11)
    ) dut0 (
        .clk(clk), .asyn_reset(asyn_reset), .start(s_start),
        .x_value(x_value), .d_value(d_value), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .q_value(q_value),
        .x_value_comp(s_x_comp), .d_value_comp(s_d_comp),
        .enable(s_enable), .refresh(s_refresh), .counter(s_counter),
        .wr_addr(s_wr_addr), .q_out(s_q_out), .q_valid(s_q_valid),
        .busy(s_busy), .done(s_done), .digit_err(s_digit_err)
    );

    function automatic logic [1:0] sdpat(input int k);
        case (k % 3)
            0:       return 2'b10;
            1:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [30:0] all_outs();
        return {in_ready, x_value_comp, d_value_comp, enable, refresh, counter,
                wr_addr, q_out, q_valid, busy, done, digit_err};
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // The datapath quotient digit follows a fixed pattern of the cycle index.
    initial begin
        q_value = sdpat(0);
        forever begin
            @(posedge clk);
            #1;
            q_value = sdpat(cyc);
        end
    end

    initial begin
        en_t e;
        q_t  qe;
        forever begin
            @(negedge clk);
            if (refresh && enable) checkOutput("refresh_enable_overlap", 1, 0);
            if (done && !q_valid) checkOutput("done_without_q_valid", 1, 0);
            if (enable) begin
                if (enq.size() == 0) begin
                    checkOutput("unexpected_enable", int'(counter), -1);
                end else begin
                    e = enq.pop_front();
                    checkOutput("enable_cycle", cyc, e.cyc);
                    checkOutput("counter", int'(counter), e.cnt);
                    checkOutput("wr_addr", int'(wr_addr), e.cnt % 128);
                    checkOutput("x_value_comp", int'(x_value_comp), int'(e.xc));
                    checkOutput("d_value_comp", int'(d_value_comp), int'(e.dc));
                end
            end
            if (q_valid) begin
                if (qq.size() == 0) begin
                    checkOutput("unexpected_q_valid", int'(q_out), -1);
                end else begin
                    qe = qq.pop_front();
                    checkOutput("q_valid_cycle", cyc, qe.cyc);
                    checkOutput("q_out", int'(q_out), int'(qe.q));
                    checkOutput("done", int'(done), int'(qe.dn));
                end
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            checkOutput("idle_busy", int'(busy), 0);
        end
    endtask

    // Called at cycle 0 of an operation; returns in the cycle busy is low again.
    task automatic applyStimulus(input bit gap, input int err_step, input bit hold,
                                 input int abort_step);
        int  base, acc, done_c, err_accept, c;
        bit  finished;
        en_t e;
        q_t  qe;
        base = cyc;
        acc = 0;
        done_c = -1;
        err_accept = -1;
        finished = 1'b0;
        start = 1'b1;
        for (int rel = 0; rel < 400 && !finished; rel++) begin
            if (rel > 0) begin
                @(posedge clk);
                #1;
            end
            c = base + rel;
            if (rel == 2) err_model = 1'b0;
            if (err_accept >= 0 && c == err_accept + 1) err_model = 1'b1;
            if (rel >= 1) checkOutput("digit_err", int'(digit_err), int'(err_model));
            if (rel == 1) begin
                checkOutput("refresh_pulse", int'(refresh), 1);
                checkOutput("busy_rise", int'(busy), 1);
            end else if (rel >= 2) begin
                checkOutput("refresh_quiet", int'(refresh), 0);
            end
            if (done_c >= 0 && c == done_c) checkOutput("busy_at_done", int'(busy), 1);
            if (done_c >= 0 && c == done_c + 1) begin
                checkOutput("busy_fall", int'(busy), 0);
                finished = 1'b1;
            end else begin
                if (rel == 1 && !hold) start = 1'b0;
                in_valid = gap ? (rel % 2 == 0) : 1'b1;
                x_value = (acc == err_step) ? 2'b11 : sdpat(acc);
                d_value = sdpat(acc + 1);
                if (rel >= 2 && acc < P && in_valid) begin
                    e.cyc = c + 1;
                    e.cnt = acc;
                    e.xc  = (acc == err_step) ? 2'b00 : sdpat(acc);
                    e.dc  = sdpat(acc + 1);
                    enq.push_back(e);
                    if (acc >= D) begin
                        qe.cyc = c + 2;
                        qe.q   = sdpat(c + 1);
                        qe.dn  = (acc == P + D - 1);
                        qq.push_back(qe);
                    end
                    if (acc == err_step) err_accept = c;
                    acc++;
                    if (acc == P) begin
                        for (int j = 0; j < D; j++) begin
                            e.cyc = c + 2 + j;
                            e.cnt = P + j;
                            e.xc  = 2'b00;
                            e.dc  = 2'b00;
                            enq.push_back(e);
                            qe.cyc = c + 3 + j;
                            qe.q   = sdpat(c + 2 + j);
                            qe.dn  = (j == D - 1);
                            qq.push_back(qe);
                        end
                        done_c = c + D + 2;
                    end
                end
                if (abort_step >= 0 && acc == abort_step + 1) begin
                    #1;
                    asyn_reset = 1'b1;
                    #1;
                    checkOutput("reset_mid_iter_outputs", int'(all_outs()), 0);
                    enq.delete();
                    qq.delete();
                    err_model = 1'b0;
                    start = 1'b0;
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        if (!finished) checkOutput("operation_timeout", 1, 0);
        checkOutput("enable_queue_drained", enq.size(), 0);
        checkOutput("q_queue_drained", qq.size(), 0);
    endtask

    // Zero online delay: strobes in cycles 3..10, quotient digits in 4..11.
    task automatic runSmallOp();
        int base, rel_i;
        base = cyc;
        s_start = 1'b1;
        s_in_valid = 1'b1;
        for (int rel = 0; rel < 14; rel++) begin
            if (rel > 0) begin
                @(posedge clk);
                #1;
            end
            rel_i = rel;
            checkOutput("d0_refresh", int'(s_refresh), int'(rel_i == 1));
            checkOutput("d0_in_ready", int'(s_in_ready), int'(rel_i >= 2 && rel_i <= 9));
            checkOutput("d0_enable", int'(s_enable), int'(rel_i >= 3 && rel_i <= 10));
            if (rel_i >= 3 && rel_i <= 10)
                checkOutput("d0_counter", int'(s_counter), rel_i - 3);
            checkOutput("d0_q_valid", int'(s_q_valid), int'(rel_i >= 4 && rel_i <= 11));
            if (rel_i >= 4 && rel_i <= 11)
                checkOutput("d0_q_out", int'(s_q_out), int'(sdpat(base + rel_i - 1)));
            checkOutput("d0_done", int'(s_done), int'(rel_i == 11));
            checkOutput("d0_busy", int'(s_busy), int'(rel_i >= 1 && rel_i <= 11));
            if (rel == 1) s_start = 1'b0;
        end
        s_in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        asyn_reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        x_value = 2'b00;
        d_value = 2'b00;
        s_start = 1'b0;
        s_in_valid = 1'b0;
        #2;
        checkOutput("reset_outputs", int'(all_outs()), 0);
        repeat (2) @(posedge clk);
        #1;
        asyn_reset = 1'b0;
        idleCycles(3);

        applyStimulus(1'b0, -1, 1'b0, -1);
        idleCycles(3);
        applyStimulus(1'b1, -1, 1'b0, -1);
        idleCycles(2);
        applyStimulus(1'b0, 5, 1'b0, -1);
        idleCycles(2);
        checkOutput("digit_err_sticky_idle", int'(digit_err), 1);
        applyStimulus(1'b0, -1, 1'b1, -1);
        applyStimulus(1'b0, -1, 1'b0, -1);
        idleCycles(2);

        applyStimulus(1'b0, -1, 1'b0, 20);
        @(posedge clk);
        #1;
        checkOutput("reset_held_busy", int'(busy), 0);
        asyn_reset = 1'b0;
        idleCycles(3);
        applyStimulus(1'b0, -1, 1'b0, -1);
        idleCycles(2);

        runSmallOp();
        idleCycles(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
